// File: rtl/codec_bus_slave.sv
// codec_bus_slave: memory-mapped register and sample-FIFO slave for the WM8731 codec controller
module codec_bus_slave #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic        slave_chipselect,
    input  logic [2:0]  slave_address,
    input  logic [31:0] slave_writedata,
    output logic [31:0] slave_readdata,
    output logic        slave_waitrequest,
    input  logic        slave_beginbursttransfer,
    input  logic [7:0]  slave_burstcount,
    output logic        slave_irq,
    output logic [23:0] i2c_packet,
    output logic        i2c_start,
    input  logic        i2c_busy,
    output logic [31:0] dac_data,
    output logic        dac_valid,
    input  logic        dac_ready,
    input  logic [31:0] adc_data,
    input  logic        adc_valid
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, RWAIT, RDONE, BURST} state_t;
    state_t state, state_nx;
    logic [31:0] dac_mem [FIFO_DEPTH];
    logic [31:0] adc_mem [FIFO_DEPTH];
    logic [AW:0] dac_wp, dac_rp, adc_wp, adc_rp;
    logic [31:0] i2c_reg, status, rd_val;
    logic [2:0]  ctrl;
    logic [7:0]  beats;
    logic        i2c_done, adc_ovf, busy_q;
    logic        dac_full, dac_empty, adc_full, adc_empty;
    logic        rd, wr, wr_acc, rd_acc, capture;
    logic        dac_push, dac_pop, adc_push, adc_pop, clr_sticky;

    assign dac_empty = dac_wp == dac_rp;
    assign adc_empty = adc_wp == adc_rp;
    assign dac_full  = (dac_wp[AW] != dac_rp[AW]) && (dac_wp[AW-1:0] == dac_rp[AW-1:0]);
    assign adc_full  = (adc_wp[AW] != adc_rp[AW]) && (adc_wp[AW-1:0] == adc_rp[AW-1:0]);

    assign rd = slave_chipselect & slave_read;
    assign wr = slave_chipselect & slave_write & ~slave_read;
    assign slave_waitrequest = (rd & (state != RDONE)) |
                               (wr & (((slave_address == 3'd2) & dac_full) |
                                      ((slave_address == 3'd1) & (i2c_busy | i2c_start))));
    assign wr_acc = wr & ~slave_waitrequest;
    assign rd_acc = rd & (state == RDONE);

    assign dac_push   = wr_acc & (slave_address == 3'd2);
    assign dac_pop    = dac_valid & dac_ready;
    assign adc_push   = adc_valid & ~adc_full;
    assign adc_pop    = rd_acc & (slave_address == 3'd3);
    assign clr_sticky = rd_acc & (slave_address == 3'd0);

    assign dac_valid  = ~dac_empty;
    assign dac_data   = dac_mem[dac_rp[AW-1:0]];
    assign i2c_packet = i2c_reg[23:0];

    assign status = {24'd0, beats != 8'd0, adc_ovf, i2c_done, dac_empty, adc_empty, adc_full, dac_full, i2c_busy};
    assign rd_val = slave_address == 3'd0 ? status :
                    slave_address == 3'd1 ? i2c_reg :
                    slave_address == 3'd3 ? adc_mem[adc_rp[AW-1:0]] :
                    slave_address == 3'd4 ? {29'd0, ctrl} : 32'd0;

    // Each beat first captures (IDLE/BURST/RWAIT), then completes in RDONE.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        case (state)
            IDLE, BURST: if (rd) begin
                if (slave_address == 3'd3 && adc_empty) state_nx = RWAIT;
                else begin
                    capture  = 1'b1;
                    state_nx = RDONE;
                end
            end
            RWAIT: if (!adc_empty) begin
                capture  = 1'b1;
                state_nx = RDONE;
            end
            default: if (rd) state_nx = beats > 8'd1 ? BURST : IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (dac_push) dac_mem[dac_wp[AW-1:0]] <= slave_writedata;
        if (adc_push) adc_mem[adc_wp[AW-1:0]] <= adc_data;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state          <= IDLE;
            dac_wp         <= '0;
            dac_rp         <= '0;
            adc_wp         <= '0;
            adc_rp         <= '0;
            i2c_reg        <= '0;
            i2c_start      <= 1'b0;
            ctrl           <= '0;
            beats          <= '0;
            i2c_done       <= 1'b0;
            adc_ovf        <= 1'b0;
            busy_q         <= 1'b0;
            slave_readdata <= '0;
            slave_irq      <= 1'b0;
        end else begin
            state     <= state_nx;
            dac_wp    <= dac_wp + {{AW{1'b0}}, dac_push};
            dac_rp    <= dac_rp + {{AW{1'b0}}, dac_pop};
            adc_wp    <= adc_wp + {{AW{1'b0}}, adc_push};
            adc_rp    <= adc_rp + {{AW{1'b0}}, adc_pop};
            i2c_start <= wr_acc & (slave_address == 3'd1);
            busy_q    <= i2c_busy;
            // A new sticky event takes priority over a same-cycle STATUS read-clear.
            i2c_done  <= (busy_q & ~i2c_busy) | (i2c_done & ~clr_sticky);
            adc_ovf   <= (adc_valid & adc_full) | (adc_ovf & ~clr_sticky);
            slave_irq <= |(ctrl & {i2c_done, dac_empty, ~adc_empty});
            if (wr_acc && slave_address == 3'd1) i2c_reg <= slave_writedata;
            if (wr_acc && slave_address == 3'd4) ctrl <= slave_writedata[2:0];
            if (capture) slave_readdata <= rd_val;
            if (state == IDLE && rd && slave_beginbursttransfer)
                beats <= slave_burstcount == 8'd0 ? 8'd1 : slave_burstcount;
            else if (rd_acc && beats != 8'd0)
                beats <= beats - 8'd1;
        end
    end
endmodule

// File: tb/tb_codec_bus_slave.sv
// tb_codec_bus_slave: vector-table plus scoreboard bench for codec_bus_slave
module tb_codec_bus_slave;
    logic        Clk = 1'b0, Rst = 1'b1;
    logic        rd = 1'b0, wr = 1'b0, cs = 1'b0, bb = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [7:0]  bc = '0;
    logic [31:0] readdata, dac_data;
    logic        waitreq, irq, start, dac_valid;
    logic [23:0] packet;
    logic        busy = 1'b0, dac_ready = 1'b0, adc_valid = 1'b0;
    logic [31:0] adc_data = '0;
    int          compared = 0, mismatched = 0, starts = 0, drained = 0, w = 0, wsum = 0;
    logic [31:0] sb[$];
    logic [31:0] dac_q[$];

    typedef struct {
        logic        is_wr;
        logic [2:0]  a;
        logic [31:0] d;
    } vec_t;
    vec_t vecs[14];

    always #5 Clk = ~Clk;

    codec_bus_slave #(.FIFO_DEPTH(8)) dut (
        .Clk(Clk), .Rst(Rst),
        .slave_read(rd), .slave_write(wr), .slave_chipselect(cs),
        .slave_address(addr), .slave_writedata(wdata), .slave_readdata(readdata),
        .slave_waitrequest(waitreq), .slave_beginbursttransfer(bb), .slave_burstcount(bc),
        .slave_irq(irq), .i2c_packet(packet), .i2c_start(start), .i2c_busy(busy),
        .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
        .adc_data(adc_data), .adc_valid(adc_valid)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, output int waits);
        @(negedge Clk);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d; waits = 0;
        #1;
        while (waitreq && waits < 100) begin
            @(negedge Clk); #1;
            waits++;
        end
        if (waitreq) chk("write_timeout", {31'd0, waitreq}, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic burst, input logic [7:0] count,
                            input int beats, input string nm);
        int n;
        @(negedge Clk);
        cs = 1'b1; rd = 1'b1; addr = a; bb = burst; bc = count;
        for (int b = 0; b < beats; b++) begin
            n = 0;
            #1;
            while (waitreq && n < 100) begin
                @(negedge Clk);
                bb = 1'b0;
                #1;
                n++;
            end
            if (waitreq) begin
                chk({nm, "_timeout"}, {31'd0, waitreq}, 32'd0);
                break;
            end
            if (sb.size() == 0) chk({nm, "_no_expect"}, readdata, 32'hDEAD_BEEF);
            else chk(nm, readdata, sb.pop_front());
            @(posedge Clk);
            @(negedge Clk);
            bb = 1'b0;
        end
        cs = 1'b0; rd = 1'b0; bb = 1'b0;
    endtask

    task automatic status_is(input logic [31:0] exp, input string nm);
        sb.push_back(exp);
        bus_read(3'd0, 1'b0, 8'd0, 1, nm);
    endtask

    task automatic adc_push_n(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            adc_valid = 1'b1; adc_data = base + 32'(i);
        end
        @(negedge Clk);
        adc_valid = 1'b0;
    endtask

    // Observe i2c_start pulses and DAC pops mid-cycle, away from the clock edges.
    always @(negedge Clk) begin
        #2;
        if (start === 1'b1) starts++;
        if (dac_valid === 1'b1 && dac_ready === 1'b1) begin
            if (dac_q.size() == 0) chk("dac_extra_pop", dac_data, 32'hDEAD_BEEF);
            else chk("dac_order", dac_data, dac_q.pop_front());
            drained++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 32'h0000_0018};
        vecs[1]  = '{1'b0, 3'd2, 32'h0000_0000};
        vecs[2]  = '{1'b1, 3'd4, 32'hFFFF_FFF8};
        vecs[3]  = '{1'b0, 3'd4, 32'h0000_0000};
        vecs[4]  = '{1'b1, 3'd4, 32'h0000_0005};
        vecs[5]  = '{1'b0, 3'd4, 32'h0000_0005};
        vecs[6]  = '{1'b1, 3'd5, 32'h0000_DEAD};
        vecs[7]  = '{1'b0, 3'd5, 32'h0000_0000};
        vecs[8]  = '{1'b1, 3'd7, 32'h0000_0001};
        vecs[9]  = '{1'b0, 3'd7, 32'h0000_0000};
        vecs[10] = '{1'b1, 3'd4, 32'h0000_0000};
        vecs[11] = '{1'b0, 3'd4, 32'h0000_0000};
        vecs[12] = '{1'b0, 3'd6, 32'h0000_0000};
        vecs[13] = '{1'b0, 3'd1, 32'h0000_0000};

        repeat (3) @(negedge Clk);
        #1;
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_packet", {8'd0, packet}, 32'd0);
        chk("rst_dac_valid", {31'd0, dac_valid}, 32'd0);
        chk("rst_waitreq", {31'd0, waitreq}, 32'd0);
        Rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) bus_write(vecs[i].a, vecs[i].d, w);
            else begin
                sb.push_back(vecs[i].d);
                bus_read(vecs[i].a, 1'b0, 8'd0, 1, $sformatf("vec%0d", i));
            end
        end

        bus_write(3'd4, 32'd2, w);
        repeat (2) @(negedge Clk);
        chk("irq_dac_empty", {31'd0, irq}, 32'd1);
        bus_write(3'd4, 32'd1, w);
        repeat (2) @(negedge Clk);
        chk("irq_masked", {31'd0, irq}, 32'd0);
        bus_write(3'd4, 32'd0, w);

        bus_write(3'd1, 32'h0000_1E00, w);
        repeat (3) @(negedge Clk);
        chk("i2c_starts1", 32'(starts), 32'd1);
        chk("i2c_packet1", {8'd0, packet}, 32'h0000_1E00);
        sb.push_back(32'h0000_1E00);
        bus_read(3'd1, 1'b0, 8'd0, 1, "i2c_readback1");

        @(negedge Clk);
        busy = 1'b1;
        fork
            bus_write(3'd1, 32'hAB00_2A34, w);
            begin
                repeat (5) @(negedge Clk);
                busy = 1'b0;
            end
        join
        chk("i2c_stall_waits", 32'(w), 32'd4);
        repeat (3) @(negedge Clk);
        chk("i2c_starts2", 32'(starts), 32'd2);
        chk("i2c_packet2", {8'd0, packet}, 32'h0000_2A34);
        status_is(32'h0000_0038, "status_i2c_done");
        status_is(32'h0000_0018, "status_done_cleared");
        sb.push_back(32'hAB00_2A34);
        bus_read(3'd1, 1'b0, 8'd0, 1, "i2c_readback2");

        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            dac_q.push_back(32'h100 + 32'(i));
            bus_write(3'd2, 32'h100 + 32'(i), w);
            wsum += w;
        end
        chk("dac_fill_waits", 32'(wsum), 32'd0);
        status_is(32'h0000_000A, "status_dac_full");
        dac_q.push_back(32'h108);
        fork
            bus_write(3'd2, 32'h108, w);
            begin
                repeat (4) @(negedge Clk);
                dac_ready = 1'b1;
            end
        join
        chk("dac_stall_waits", 32'(w), 32'd4);
        for (int k = 0; k < 100 && dac_q.size() != 0; k++) @(negedge Clk);
        repeat (2) @(negedge Clk);
        chk("dac_drained", 32'(drained), 32'd9);
        dac_ready = 1'b0;
        #3;
        chk("dac_valid_empty", {31'd0, dac_valid}, 32'd0);

        adc_push_n(32'hA0, 4);
        status_is(32'h0000_0010, "status_adc_nonempty");
        for (int i = 0; i < 4; i++) sb.push_back(32'hA0 + 32'(i));
        bus_read(3'd3, 1'b1, 8'd4, 4, "adc_burst");
        status_is(32'h0000_0018, "status_after_burst");
        repeat (3) sb.push_back(32'hAB00_2A34);
        bus_read(3'd1, 1'b1, 8'd3, 3, "burst_reg");
        sb.push_back(32'd0);
        bus_read(3'd4, 1'b1, 8'd0, 1, "burst_zero");
        status_is(32'h0000_0018, "status_burst_zero");

        adc_push_n(32'hB0, 9);
        status_is(32'h0000_0054, "status_overflow");
        status_is(32'h0000_0014, "status_ovf_cleared");
        for (int i = 0; i < 8; i++) begin
            sb.push_back(32'hB0 + 32'(i));
            bus_read(3'd3, 1'b0, 8'd0, 1, $sformatf("adc_ovf_pop%0d", i));
        end
        status_is(32'h0000_0018, "status_adc_drained");

        sb.push_back(32'h55);
        fork
            bus_read(3'd3, 1'b0, 8'd0, 1, "adc_rwait");
            begin
                repeat (4) @(negedge Clk);
                adc_data = 32'h55; adc_valid = 1'b1;
                @(negedge Clk);
                adc_valid = 1'b0;
            end
        join

        @(negedge Clk);
        cs = 1'b1; rd = 1'b1; addr = 3'd3;
        repeat (3) @(negedge Clk);
        #1;
        chk("rwait_hold", {31'd0, waitreq}, 32'd1);
        chk("rwait_readdata", readdata, 32'h55);
        @(negedge Clk);
        Rst = 1'b1; cs = 1'b0; rd = 1'b0;
        @(negedge Clk);
        #1;
        chk("rst2_readdata", readdata, 32'd0);
        chk("rst2_packet", {8'd0, packet}, 32'd0);
        chk("rst2_waitreq", {31'd0, waitreq}, 32'd0);
        chk("rst2_irq", {31'd0, irq}, 32'd0);
        chk("rst2_start", {31'd0, start}, 32'd0);
        chk("rst2_dac_valid", {31'd0, dac_valid}, 32'd0);
        Rst = 1'b0;
        status_is(32'h0000_0018, "status_after_reset");
        sb.push_back(32'd0);
        bus_read(3'd1, 1'b0, 8'd0, 1, "i2c_after_reset");
        if (sb.size() != 0) chk("scoreboard_leftover", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/codec_bus_slave.md
# codec_bus_slave

Synthesizable memory-mapped slave for the WM8731 codec controller: the responder to the bus master's read/write/burst-read transactions. It decodes a 3-bit register space, buffers DAC samples and ADC samples in two FIFOs, and launches I2C configuration packets. It throttles the master with `slave_waitrequest` and raises `slave_irq` on enabled events. It sits between the system bus and the codec serial/I2C engines.

## Interface
- `FIFO_DEPTH`, 8: entries per sample FIFO; a power of two, minimum 2.
- `Clk`  in  1  system clock; all logic rising-edge.
- `Rst`  in  1  synchronous, active-high reset.
- `slave_read`, `slave_write`, `slave_chipselect`  in  1 each  access strobes; an access is valid only when chipselect is high.
- `slave_address`  in  3  register select.
- `slave_writedata`  in  32  write data.
- `slave_readdata`  out  32  registered read data.
- `slave_waitrequest`  out  1  stall; combinational from state and flags.
- `slave_beginbursttransfer`  in  1  first-cycle burst marker.
- `slave_burstcount`  in  8  beats in the burst (1..255).
- `slave_irq`  out  1  level interrupt.
- `i2c_packet`  out  24  packet to the I2C engine.
- `i2c_start`  out  1  one-cycle launch pulse.
- `i2c_busy`  in  1  I2C engine busy.
- `dac_data`  out  32  DAC FIFO head.
- `dac_valid`  out  1  DAC FIFO not empty.
- `dac_ready`  in  1  pops the DAC FIFO when `dac_valid` is high.
- `adc_data`  in  32  ADC sample.
- `adc_valid`  in  1  pushes the ADC FIFO.

## Operation
- **Address map:**
  - 0 STATUS, read-only, read-clears sticky bits: [0] i2c_busy; [1] DAC full; [2] ADC full; [3] ADC empty; [4] DAC empty; [5] i2c_done sticky; [6] ADC overflow sticky; [7] burst active.
  - 1 I2C_DATA, R/W: [23:0] packet, [31:24] stored for readback only.
  - 2 DAC_AUDIO, write-only: pushes the DAC FIFO; reads return 0.
  - 3 ADC_AUDIO, read-only: pops the ADC FIFO.
  - 4 CONTROL, R/W [2:0] irq enables: [0] ADC not empty; [1] DAC empty; [2] i2c_done.
  - 5–7: reads return 0; writes are accepted and ignored.
- **Acceptance:** a transfer completes at a rising edge where chipselect, the strobe is high and `slave_waitrequest`=0. Exactly one side effect occurs per completed transfer.
- **Writes:** zero wait by default. `slave_waitrequest`=1 in two cases:
  - addr 2 while the DAC FIFO is full;
  - addr 1 while `i2c_busy` is high or `i2c_start` is pending.
- **I2C write:** on acceptance, latch the register; `i2c_start`=1 on the following cycle only.
- **i2c_done:** set on the falling edge of `i2c_busy`.
- **Read FSM states:** IDLE, RWAIT, RDONE, BURST.
  - IDLE: a read with chipselect → waitrequest=1. The selected value is captured into `slave_readdata` at that edge; go to RDONE. For addr 3 with the ADC FIFO empty, go to RWAIT instead.
  - RWAIT: waitrequest=1 until the ADC FIFO is non-empty, then capture the head and go to RDONE.
  - RDONE: waitrequest=0. At the acceptance edge the ADC FIFO pops (addr 3) and STATUS sticky bits clear (addr 0). Return to IDLE, or to BURST if beats remain.
  - `slave_readdata` holds its value until the next capture.
- **Burst read:** `slave_beginbursttransfer` with a read loads a beat counter from `slave_burstcount`.
  - Each accepted beat pops once and decrements the counter.
  - Capture follows the RWAIT/RDONE rules per beat.
  - STATUS[7]=1 while the counter is non-zero.
  - A burst to an address other than 3 returns the same register value for every beat.
  - burstcount=0 is treated as 1.
- **ADC push:** on `adc_valid` when full, the sample is dropped and overflow is set; the FIFO is unchanged.
- **Simultaneous events:**
  - Pop and push on the same cycle: level is unchanged and both take effect.
  - A sticky-set event on the same cycle as a STATUS read-clear: the set wins.
- **IRQ:** `slave_irq` = OR of enabled conditions, registered (one-cycle delay).

## Timing
- **Reset values:**
  - `slave_readdata`=0, `slave_irq`=0, `i2c_start`=0, `i2c_packet`=0.
  - `dac_valid`=0, `slave_waitrequest`=0 (when no access).
  - FIFOs empty, CONTROL=0, stickies=0, FSM in IDLE.
- **Latency:**
  - Single read: 2 cycles minimum (1 wait cycle + 1 accept cycle).
  - Write: 1 cycle.
  - `i2c_start`: 1 cycle after write acceptance.
  - DAC FIFO: `dac_valid` rises 1 cycle after the push.
  - ADC FIFO: STATUS[3] clears 1 cycle after `adc_valid`.
- **Full/empty:** full means level = FIFO_DEPTH. Pointers use one extra wrap bit; wrap-around is transparent.
- **Reset mid-transfer:** the FSM returns to IDLE and FIFOs flush. `i2c_start` deasserts on the same edge. A master strobe held across reset is re-decoded as a new access.

## Test plan
- **I2C write:** write addr 1 = 0x0000_1E00 → one `i2c_packet`=0x001E00 and one `i2c_start` pulse; readback = 0x0000_1E00.
- **I2C stall:** second I2C write while `i2c_busy`=1 → waitrequest stays high until busy falls; then exactly one more start pulse; STATUS[5] sets and clears on a STATUS read.
- **DAC fill:** write 9 samples 0x100..0x108 with FIFO_DEPTH=8 and `dac_ready`=0 → the 9th write stalls. Raising `dac_ready` releases it; samples drain in order 0x100..0x108.
- **ADC burst:** push 0xA0..0xA3, then burst read addr 3 with burstcount 4 → readdata 0xA0,0xA1,0xA2,0xA3; STATUS[3]=1 afterward; STATUS[7]=0.
- **ADC overflow:** 9 pushes with no reads → STATUS reads [2]=1, [6]=1; a second STATUS read gives [6]=0; FIFO contents are the first 8 samples.
- **Read on empty / reset:** read addr 3 on an empty FIFO holds waitrequest until `adc_valid` with 0x55 → readdata 0x55. Assert `Rst` during RWAIT → all outputs return to reset values the next cycle.
